// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial MSB-first pattern burst generator with repeat count and inter-frame gap
module seq_pattern_gen #(
    parameter int PAT_W = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap_len,
    output logic             x_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);
    localparam int IW = $clog2(PAT_W);
    localparam logic [IW-1:0] MSB = IW'(PAT_W - 1);
    localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2, FIN = 2'd3;
    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [CNT_W-1:0] frm;
    logic [GAP_W-1:0] gap, gcnt;
    // Registers hold what is on the line this cycle; frm counts frames still owed including the current one.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            frm         <= '0;
            gap         <= '0;
            gcnt        <= '0;
            x_out       <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: if (start && !abort) begin
                    state       <= SEND;
                    idx         <= MSB;
                    frm         <= (repeat_n == '0) ? CNT_W'(1) : repeat_n;
                    gap         <= gap_len;
                    x_out       <= PATTERN[PAT_W-1];
                    bit_valid   <= 1'b1;
                    frame_start <= 1'b1;
                    busy        <= 1'b1;
                end
                SEND: if (abort) begin
                    state     <= IDLE;
                    x_out     <= 1'b0;
                    bit_valid <= 1'b0;
                    busy      <= 1'b0;
                end else if (idx != '0) begin
                    idx   <= idx - 1'b1;
                    x_out <= PATTERN[idx - 1'b1];
                end else if (frm == CNT_W'(1)) begin
                    state     <= FIN;
                    frm       <= '0;
                    x_out     <= 1'b0;
                    bit_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end else if (gap == '0) begin
                    frm         <= frm - 1'b1;
                    idx         <= MSB;
                    x_out       <= PATTERN[PAT_W-1];
                    frame_start <= 1'b1;
                end else begin
                    state     <= GAP;
                    frm       <= frm - 1'b1;
                    gcnt      <= gap - 1'b1;
                    x_out     <= 1'b0;
                    bit_valid <= 1'b0;
                end
                GAP: if (abort) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (gcnt == '0) begin
                    state       <= SEND;
                    idx         <= MSB;
                    x_out       <= PATTERN[PAT_W-1];
                    bit_valid   <= 1'b1;
                    frame_start <= 1'b1;
                end else begin
                    gcnt <= gcnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial bit-pattern generator: the transmit side for the team's Moore non-overlapping sequence detectors.
- On a start request it drives a parameterised bit pattern MSB-first onto a 1-bit serial line, one bit per clock.
- It repeats the pattern a programmable number of times, with an optional idle gap between frames.
- Used as stimulus source and loopback partner for detector blocks (its x_out feeds the detector's x input).

Parameters:
- PAT_W, 4, pattern length in bits (legal 2..16).
- PATTERN, 4'b1011, pattern to transmit; bit PAT_W-1 is sent first.
- CNT_W, 4, width of the repetition-count input.
- GAP_W, 3, width of the inter-frame gap-length input.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a burst; sampled only in IDLE.
- abort  input  1  synchronous abort; ends the burst immediately.
- repeat_n  input  CNT_W  number of frames in the burst; 0 is treated as 1; latched on start.
- gap_len  input  GAP_W  idle cycles between frames; latched on start.
- x_out  output  1  serial data; 0 when not sending.
- bit_valid  output  1  high while x_out carries a pattern bit.
- frame_start  output  1  high on the cycle the first (MSB) bit of each frame is driven.
- busy  output  1  high from the cycle after start is accepted until the burst ends.
- done  output  1  one-cycle pulse after the last bit of the last frame.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n. Assertion forces state IDLE and clears all registers.
- Reset values: x_out=0, bit_valid=0, frame_start=0, busy=0, done=0, bit index=0, frame count=0, gap count=0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, SEND, GAP, FIN.
- IDLE:
  - start=1 and abort=0 at an edge: latch repeat_n (0 -> 1) and gap_len, then enter SEND.
  - On the next cycle: x_out=PATTERN[PAT_W-1], bit_valid=1, frame_start=1, busy=1. Latency from start to first bit is 1 cycle.
- SEND:
  - Bit index counts PAT_W-1 down to 0; x_out=PATTERN[index] each cycle.
  - frame_start is high only for index PAT_W-1.
  - After index 0, if frames remain and gap=0: the next cycle begins the next frame (MSB, frame_start=1). Frames are back-to-back with no bubble.
  - After index 0, if frames remain and gap>0: enter GAP.
  - After index 0 of the last frame: enter FIN.
- GAP:
  - Lasts exactly gap_len cycles with x_out=0, bit_valid=0, busy=1.
  - Then the next frame's MSB is driven with frame_start=1.
- FIN:
  - One cycle: done=1, busy=0, x_out=0, bit_valid=0. Then IDLE.
  - A start present during FIN is ignored. The earliest new start is accepted in IDLE on the following edge.
- start while busy (SEND/GAP) is ignored. The latched repeat_n and gap_len are not affected by later input changes.
- abort=1 in SEND or GAP:
  - Next cycle: IDLE with x_out=0, bit_valid=0, busy=0, frame_start=0. done is not pulsed. The partial frame is truncated.
  - abort has priority over start and over frame/bit advancement.
- abort in IDLE or FIN has no effect beyond the normal FIN->IDLE transition.
- Reset mid-burst returns to IDLE asynchronously, outputs 0, no done.
- Total busy cycles for a burst of N frames = N*PAT_W + (N-1)*gap_len.
- Frame counter width is CNT_W. Maximum burst length is 2^CNT_W-1 frames; there is no wrap-around.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, then release with start=0 -> all outputs 0 for 10 cycles.
- Single frame, defaults: start=1 for 1 cycle, repeat_n=1, gap_len=0 -> x_out 1,0,1,1 on cycles 1-4 after start; frame_start on cycle 1 only; done=1 on cycle 5; busy high on cycles 1-4.
- Back-to-back burst into loopback detector (1011 non-overlapping): repeat_n=3, gap_len=0 -> x_out 101110111011 with 12 valid cycles; frame_start on cycles 1, 5, 9; detector z asserts 3 times; done on cycle 13.
- Gapped burst: repeat_n=2, gap_len=2 -> 1011, 00 (bit_valid=0), 1011; done on cycle 11; repeat_n=0 gives exactly one frame.
- Abort: repeat_n=3, assert abort on the 2nd bit of frame 2 -> IDLE next cycle, x_out=0, busy=0, done never pulses; a new start after that is accepted normally.
- Ignored start and async reset: pulse start during SEND -> burst length unchanged; deassert rst_n mid-GAP -> outputs 0 immediately, before the next clk edge.
